// File: rtl/multicycle_control.sv
// Control FSM for a multicycle RV32 subset datapath (lw, sw, R/I ALU, beq, jal).
// Outputs are decoded from the current state plus mem_ready/zero/instruction fields where needed.
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [1:0] immediate_source,
    output logic       illegal_instruction,
    output logic [3:0] state
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTER = 4'd6;
    localparam logic [3:0] S_EXECUTEI = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BEQ      = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_ERROR    = 4'd15;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic [2:0] w_alu_dec;
    logic       w_f3_ok;

    // funct3 decode shared by both execute states; funct7_5 only selects sub for register ops
    always_comb begin
        w_alu_dec = ALU_ADD;
        w_f3_ok   = 1'b1;
        case (funct3)
            3'b000: begin
                if (r_state == S_EXECUTER && funct7_5) begin
                    w_alu_dec = ALU_SUB;
                end else begin
                    w_alu_dec = ALU_ADD;
                end
            end
            3'b111:  w_alu_dec = ALU_AND;
            3'b110:  w_alu_dec = ALU_OR;
            3'b010:  w_alu_dec = ALU_SLT;
            default: w_f3_ok   = 1'b0;
        endcase
    end

    // next-state logic; unused encodings fall into ERROR
    always_comb begin
        w_next = S_ERROR;
        case (r_state)
            S_FETCH: begin
                if (mem_ready) begin
                    w_next = S_DECODE;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R:         w_next = S_EXECUTER;
                    OP_I:         w_next = S_EXECUTEI;
                    OP_BEQ:       w_next = S_BEQ;
                    OP_JAL:       w_next = S_JAL;
                    default:      w_next = S_ERROR;
                endcase
            end
            S_MEMADR: begin
                if (opcode == OP_SW) begin
                    w_next = S_MEMWRITE;
                end else begin
                    w_next = S_MEMREAD;
                end
            end
            S_MEMREAD: begin
                if (mem_ready) begin
                    w_next = S_MEMWB;
                end else begin
                    w_next = S_MEMREAD;
                end
            end
            S_MEMWRITE: begin
                if (mem_ready) begin
                    w_next = S_FETCH;
                end else begin
                    w_next = S_MEMWRITE;
                end
            end
            S_EXECUTER, S_EXECUTEI: begin
                if (w_f3_ok) begin
                    w_next = S_ALUWB;
                end else begin
                    w_next = S_ERROR;
                end
            end
            S_MEMWB, S_ALUWB, S_BEQ: w_next = S_FETCH;
            S_JAL:                   w_next = S_ALUWB;
            default:                 w_next = S_ERROR;
        endcase
    end

    // state register; reset wins over every transition, including ERROR
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // per-state output decode, everything not named for a state stays zero
    always_comb begin
        pc_write            = 1'b0;
        adr_src             = 1'b0;
        mem_write           = 1'b0;
        ir_write            = 1'b0;
        reg_write           = 1'b0;
        result_src          = 2'b00;
        alu_src_a           = 2'b00;
        alu_src_b           = 2'b00;
        alu_control         = ALU_ADD;
        immediate_source    = 2'b00;
        illegal_instruction = 1'b0;
        case (r_state)
            S_FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                if (opcode == OP_SW || opcode == OP_BEQ) begin
                    immediate_source = 2'b01;
                end else if (opcode == OP_JAL) begin
                    immediate_source = 2'b10;
                end else begin
                    immediate_source = 2'b00;
                end
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                if (opcode == OP_SW) begin
                    immediate_source = 2'b01;
                end else begin
                    immediate_source = 2'b00;
                end
            end
            S_MEMREAD: adr_src = 1'b1;
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECUTER: begin
                alu_src_a   = 2'b10;
                alu_control = w_alu_dec;
            end
            S_EXECUTEI: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = w_alu_dec;
            end
            S_ALUWB: reg_write = 1'b1;
            S_BEQ: begin
                alu_src_a   = 2'b10;
                alu_control = ALU_SUB;
                pc_write    = zero;
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
            end
            S_ERROR: illegal_instruction = 1'b1;
            default: illegal_instruction = 1'b0;
        endcase
    end

    assign state = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: the driver pushes hand-computed per-cycle
// expectations, a negedge monitor pops and compares the full output vector.
module tb_multicycle_control;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RR  = 7'b0110011;
    localparam logic [6:0] II  = 7'b0010011;
    localparam logic [6:0] BQ  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] BAD = 7'b1111111;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instruction;
    logic [1:0] result_src, alu_src_a, alu_src_b, immediate_source;
    logic [2:0] alu_control;
    logic [3:0] state;

    logic [20:0] exp_q[$];
    int          vec_q[$];
    int          checks = 0;
    int          errors = 0;
    int          vec_no = 0;

    multicycle_control dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
        .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
        .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_control(alu_control), .immediate_source(immediate_source),
        .illegal_instruction(illegal_instruction), .state(state)
    );

    always #5 clk = ~clk;

    // monitor: outputs are valid every cycle, compare mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [20:0] act;
            logic [20:0] e;
            int          v;
            e = exp_q.pop_front();
            v = vec_q.pop_front();
            act = {pc_write, adr_src, mem_write, ir_write, reg_write, result_src, alu_src_a,
                   alu_src_b, alu_control, immediate_source, illegal_instruction, state};
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL vec%0d {pc,adr,mw,ir,rw,rs,a,b,alu,imm,ill,st} got %b want %b", v, act, e);
            end
        end
    end

    task automatic cyc(input logic rst, input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic z, input logic mr, input logic [3:0] st,
                       input logic pc, input logic adr, input logic mw, input logic ir, input logic rw,
                       input logic [1:0] rs, input logic [1:0] a, input logic [1:0] b,
                       input logic [2:0] alu, input logic [1:0] imm, input logic ill);
        reset = rst; opcode = op; funct3 = f3; funct7_5 = f7; zero = z; mem_ready = mr;
        exp_q.push_back({pc, adr, mw, ir, rw, rs, a, b, alu, imm, ill, st});
        vec_q.push_back(vec_no);
        vec_no++;
        @(posedge clk);
        #1;
    endtask

    task automatic fetch1(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        cyc(1'b0, op, f3, f7, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 2'd0, 2'd2, 3'd0, 2'd0, 1'b0);
    endtask

    task automatic decode(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic [1:0] imm);
        cyc(1'b0, op, f3, f7, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd1, 3'd0, imm, 1'b0);
    endtask

    task automatic aluwb(input logic [6:0] op);
        cyc(1'b0, op, 3'd0, 1'b0, 1'b0, 1'b1, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 3'd0, 2'd0, 1'b0);
    endtask

    task automatic err(input logic rst);
        cyc(rst, RR, 3'd0, 1'b0, 1'b1, 1'b1, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0, 2'd0, 1'b1);
    endtask

    initial begin
        reset = 1'b1; opcode = 7'd0; funct3 = 3'd0; funct7_5 = 1'b0; zero = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // lw, zero wait: 0,1,2,3,4,0
        fetch1(LW, 3'd2, 1'b0);
        decode(LW, 3'd2, 1'b0, 2'd0);
        cyc(1'b0, LW, 3'd2, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd1, 3'd0, 2'd0, 1'b0);
        cyc(1'b0, LW, 3'd2, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0, 2'd0, 1'b0);
        cyc(1'b0, LW, 3'd2, 1'b0, 1'b0, 1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0, 2'd0, 3'd0, 2'd0, 1'b0);
        // sw: fetch stall, then three wait cycles in MEMWRITE
        cyc(1'b0, SW, 3'd2, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 2'd2, 3'd0, 2'd0, 1'b0);
        fetch1(SW, 3'd2, 1'b0);
        decode(SW, 3'd2, 1'b0, 2'd1);
        cyc(1'b0, SW, 3'd2, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd1, 3'd0, 2'd1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, SW, 3'd2, 1'b0, 1'b0, (i == 3) ? 1'b1 : 1'b0, 4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                2'd0, 2'd0, 2'd0, 3'd0, 2'd0, 1'b0);
        end
        // R sub
        fetch1(RR, 3'd0, 1'b1);
        decode(RR, 3'd0, 1'b1, 2'd0);
        cyc(1'b0, RR, 3'd0, 1'b1, 1'b0, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd0, 3'd1, 2'd0, 1'b0);
        aluwb(RR);
        // R or
        fetch1(RR, 3'd6, 1'b0);
        decode(RR, 3'd6, 1'b0, 2'd0);
        cyc(1'b0, RR, 3'd6, 1'b0, 1'b0, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd0, 3'd3, 2'd0, 1'b0);
        aluwb(RR);
        // I slt with funct7_5 set (ignored), then I add with funct7_5 set stays add
        fetch1(II, 3'd2, 1'b1);
        decode(II, 3'd2, 1'b1, 2'd0);
        cyc(1'b0, II, 3'd2, 1'b1, 1'b0, 1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd1, 3'd5, 2'd0, 1'b0);
        aluwb(II);
        fetch1(II, 3'd0, 1'b1);
        decode(II, 3'd0, 1'b1, 2'd0);
        cyc(1'b0, II, 3'd0, 1'b1, 1'b0, 1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd1, 3'd0, 2'd0, 1'b0);
        aluwb(II);
        // R funct3 001 -> ERROR, sticky until reset
        fetch1(RR, 3'd1, 1'b0);
        decode(RR, 3'd1, 1'b0, 2'd0);
        cyc(1'b0, RR, 3'd1, 1'b0, 1'b0, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd0, 3'd0, 2'd0, 1'b0);
        err(1'b0);
        err(1'b0);
        err(1'b1);
        // beq taken then not taken
        fetch1(BQ, 3'd0, 1'b0);
        decode(BQ, 3'd0, 1'b0, 2'd1);
        cyc(1'b0, BQ, 3'd0, 1'b0, 1'b1, 1'b1, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd0, 3'd1, 2'd0, 1'b0);
        fetch1(BQ, 3'd0, 1'b0);
        decode(BQ, 3'd0, 1'b0, 2'd1);
        cyc(1'b0, BQ, 3'd0, 1'b0, 1'b0, 1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd0, 3'd1, 2'd0, 1'b0);
        // jal
        fetch1(JL, 3'd0, 1'b0);
        decode(JL, 3'd0, 1'b0, 2'd2);
        cyc(1'b0, JL, 3'd0, 1'b0, 1'b0, 1'b1, 4'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd2, 3'd0, 2'd0, 1'b0);
        aluwb(JL);
        // unknown opcode in DECODE -> ERROR, cleared by reset
        fetch1(BAD, 3'd0, 1'b0);
        decode(BAD, 3'd0, 1'b0, 2'd0);
        err(1'b1);
        // reset while in MEMREAD
        fetch1(LW, 3'd2, 1'b0);
        decode(LW, 3'd2, 1'b0, 2'd0);
        cyc(1'b0, LW, 3'd2, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd1, 3'd0, 2'd0, 1'b0);
        cyc(1'b1, LW, 3'd2, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0, 2'd0, 1'b0);
        cyc(1'b0, SW, 3'd2, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 2'd2, 3'd0, 2'd0, 1'b0);
        // reset while in MEMWRITE drops mem_write next cycle
        fetch1(SW, 3'd2, 1'b0);
        decode(SW, 3'd2, 1'b0, 2'd1);
        cyc(1'b0, SW, 3'd2, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd1, 3'd0, 2'd1, 1'b0);
        cyc(1'b1, SW, 3'd2, 1'b0, 1'b0, 1'b0, 4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0, 2'd0, 1'b0);
        cyc(1'b0, SW, 3'd2, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 2'd2, 3'd0, 2'd0, 1'b0);
        repeat (2) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
